// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and func3 encodings for the RV32M multiply/divide sequencer.
// Also holds the helpers that say which operands an op treats as signed.
package mulDivPkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mulDivState_t;

    localparam logic [2:0] MUL_OP    = 3'b000;
    localparam logic [2:0] MULH_OP   = 3'b001;
    localparam logic [2:0] MULHSU_OP = 3'b010;
    localparam logic [2:0] MULHU_OP  = 3'b011;
    localparam logic [2:0] DIV_OP    = 3'b100;
    localparam logic [2:0] DIVU_OP   = 3'b101;
    localparam logic [2:0] REM_OP    = 3'b110;
    localparam logic [2:0] REMU_OP   = 3'b111;

    // MUL keeps only the low word, which does not depend on signedness.
    function automatic logic isSignedA(input logic [2:0] op);
        return (op == MULH_OP) || (op == MULHSU_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

    function automatic logic isSignedB(input logic [2:0] op);
        return (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Shift-add multiplier / restoring divider sharing one 2*XLEN accumulator.
// Driven by load/prep/step/fix strobes from the sequencer FSM.
module muldiv_datapath
    import mulDivPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic            prep_i,
    input  logic            step_i,
    input  logic            fix_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            special_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic              special_q;
    logic [XLEN-1:0]   result_q;

    logic              neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b, spec_res;
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0] step_acc, prod_fix;
    logic [XLEN-1:0]   quot, quot_fix, rem, rem_fix, fix_res;

    always_comb begin
        neg_a    = isSignedA(op_q) & a_q[XLEN-1];
        neg_b    = isSignedB(op_q) & b_q[XLEN-1];
        abs_a    = neg_a ? -a_q : a_q;
        abs_b    = neg_b ? -b_q : b_q;
        div_zero = op_q[2] && (b_q == '0);
        div_ovf  = op_q[2] && !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);
        // op[1] selects remainder among the divide ops.
        if (div_zero) spec_res = op_q[1] ? a_q : '1;
        else          spec_res = op_q[1] ? '0 : MIN_NEG;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            if (!div_trial[XLEN]) step_acc = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else                  step_acc = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot     = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        quot_fix = (neg_a_q ^ neg_b_q) ? -quot : quot;
        rem_fix  = neg_a_q ? -rem : rem;
        case (op_q)
            MUL_OP:                      fix_res = prod_fix[XLEN-1:0];
            MULH_OP, MULHSU_OP, MULHU_OP: fix_res = prod_fix[2*XLEN-1:XLEN];
            DIV_OP, DIVU_OP:             fix_res = quot_fix;
            default:                     fix_res = rem_fix;
        endcase
        if (special_q) fix_res = acc_q[XLEN-1:0];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
        end else begin
            if (load_i) begin
                op_q      <= op_i;
                a_q       <= a_i;
                b_q       <= b_i;
                special_q <= 1'b0;
            end
            if (prep_i) begin
                neg_a_q   <= neg_a;
                neg_b_q   <= neg_b;
                b_q       <= abs_b;
                special_q <= div_zero | div_ovf;
                // Special cases park their final answer in the low word.
                acc_q     <= (div_zero | div_ovf) ? {{XLEN{1'b0}}, spec_res}
                                                  : {{XLEN{1'b0}}, abs_a};
            end
            if (step_i) acc_q <= step_acc;
            if (fix_i)  result_q <= fix_res;
        end
    end

    assign special_o = special_q;
    assign result_o  = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer FSM for the RV32M multiply/divide path: accepts one op from ID/EX,
// stalls the pipeline while it iterates, and presents the result for one cycle.
//   state | meaning
//   IDLE  | waiting for startValid_i
//   PREP  | cycle 0: abs values, signs, special-case flags; cycle 1: choose RUN or DONE
//   RUN   | one shift-add / trial-subtract iteration per cycle, XLEN cycles
//   FIX   | sign correction and result select
//   DONE  | resultValid_o high for one cycle
module muldiv_sequencer
    import mulDivPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            startValid_i,
    input  logic [2:0]      mulDivOp_i,
    input  logic [XLEN-1:0] operandA_i,
    input  logic [XLEN-1:0] operandB_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            resultValid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mulDivState_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             result_valid_q;

    logic load, prep, step, fix, special;

    always_comb begin
        load = (state_q == IDLE) && startValid_i && !flush_i;
        prep = (state_q == PREP) && (cnt_q == '0) && !flush_i;
        step = (state_q == RUN) && !flush_i;
        fix  = !flush_i && ((state_q == FIX) || ((state_q == PREP) && (cnt_q != '0) && special));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= PREP;
                        cnt_q   <= '0;
                    end
                end
                PREP: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        cnt_q <= CNT_W'(1);
                    end else if (special) begin
                        state_q        <= DONE;
                        result_valid_q <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (flush_i)                         state_q <= IDLE;
                    else if (cnt_q == CNT_W'(XLEN - 1))  state_q <= FIX;
                    else                                 cnt_q   <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        state_q        <= DONE;
                        result_valid_q <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (load),
        .prep_i    (prep),
        .step_i    (step),
        .fix_i     (fix),
        .op_i      (mulDivOp_i),
        .a_i       (operandA_i),
        .b_i       (operandB_i),
        .special_o (special),
        .result_o  (result_o)
    );

    assign busy_o        = (state_q != IDLE) && (state_q != DONE);
    assign stall_o       = ((state_q == IDLE) && startValid_i) || busy_o;
    assign resultValid_o = result_valid_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, stall,
// flush and asynchronous reset behaviour against hand-computed values.
module tb_muldiv_sequencer;
    import mulDivPkg::*;

    localparam int XLEN = 32;
    localparam int LAT_NORM = XLEN + 3;
    localparam int LAT_SPEC = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start_valid = 1'b0;
    logic [2:0]      op = 3'b000;
    logic [XLEN-1:0] opa = '0;
    logic [XLEN-1:0] opb = '0;
    logic            flush = 1'b0;
    logic            stall, busy, result_valid;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fails  = 0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .startValid_i  (start_valid),
        .mulDivOp_i    (op),
        .operandA_i    (opa),
        .operandB_i    (opb),
        .flush_i       (flush),
        .stall_o       (stall),
        .busy_o        (busy),
        .resultValid_o (result_valid),
        .result_o      (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one op from IDLE and waits (bounded) for resultValid; lat = -1 on timeout.
    task automatic start_op(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                            output int lat, output logic [XLEN-1:0] res,
                            output logic stall_ok, output logic stall_done);
        @(posedge clk); #1;
        op = o; opa = x; opb = y; start_valid = 1'b1;
        lat = -1; res = '0; stall_done = 1'b1;
        #1 stall_ok = (stall === 1'b1);
        @(posedge clk); #1;
        start_valid = 1'b0; op = 3'b000; opa = '0; opb = '0;
        for (int n = 1; n <= 60; n++) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            if (result_valid === 1'b1) begin
                lat = n; res = result; stall_done = stall;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (result_valid !== 1'b0) begin n_fails++; $display("FAIL reset_rv: got %b want 0", result_valid); end
        n_checks++; if (result !== '0) begin n_fails++; $display("FAIL reset_result: got %h want 0", result); end
        n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL reset_stall_lo: got %b want 0", stall); end
        start_valid = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL reset_stall_hi: got %b want 1", stall); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_no_accept: busy %b want 0", busy); end
        start_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_mul();
        int lat; logic [XLEN-1:0] res; logic sok, sdone;
        start_op(MUL_OP, 32'd7, 32'hFFFF_FFFD, lat, res, sok, sdone);
        n_checks++; if (lat !== LAT_NORM) begin n_fails++; $display("FAIL mul_latency: got %0d want %0d", lat, LAT_NORM); end
        n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fails++; $display("FAIL mul_result: got %h want ffffffeb", res); end
        n_checks++; if (sok !== 1'b1) begin n_fails++; $display("FAIL mul_stall_busy: got %b want 1", sok); end
        n_checks++; if (sdone !== 1'b0) begin n_fails++; $display("FAIL mul_stall_done: got %b want 0", sdone); end
        @(posedge clk); #1;
        n_checks++; if (result_valid !== 1'b0) begin n_fails++; $display("FAIL mul_rv_one_cycle: got %b want 0", result_valid); end
        n_checks++; if (result !== 32'hFFFF_FFEB) begin n_fails++; $display("FAIL mul_result_hold: got %h want ffffffeb", result); end
    endtask

    task automatic test_mulh();
        int lat; logic [XLEN-1:0] res; logic sok, sdone;
        start_op(MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, sok, sdone);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fails++; $display("FAIL mulhu_result: got %h want fffffffe", res); end
        start_op(MULH_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, sok, sdone);
        n_checks++; if (res !== 32'h0000_0000) begin n_fails++; $display("FAIL mulh_result: got %h want 00000000", res); end
        n_checks++; if (lat !== LAT_NORM) begin n_fails++; $display("FAIL mulh_latency: got %0d want %0d", lat, LAT_NORM); end
        start_op(MULHSU_OP, 32'hFFFF_FFFF, 32'd2, lat, res, sok, sdone);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL mulhsu_result: got %h want ffffffff", res); end
    endtask

    task automatic test_div();
        int lat; logic [XLEN-1:0] res; logic sok, sdone;
        start_op(DIV_OP, 32'hFFFF_FFF9, 32'd2, lat, res, sok, sdone);
        n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fails++; $display("FAIL div_result: got %h want fffffffd", res); end
        n_checks++; if (lat !== LAT_NORM) begin n_fails++; $display("FAIL div_latency: got %0d want %0d", lat, LAT_NORM); end
        start_op(REM_OP, 32'hFFFF_FFF9, 32'd2, lat, res, sok, sdone);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL rem_result: got %h want ffffffff", res); end
        start_op(DIVU_OP, 32'd100, 32'd7, lat, res, sok, sdone);
        n_checks++; if (res !== 32'd14) begin n_fails++; $display("FAIL divu_result: got %h want 0000000e", res); end
        start_op(REMU_OP, 32'd100, 32'd7, lat, res, sok, sdone);
        n_checks++; if (res !== 32'd2) begin n_fails++; $display("FAIL remu_result: got %h want 00000002", res); end
    endtask

    task automatic test_special();
        int lat; logic [XLEN-1:0] res; logic sok, sdone;
        start_op(DIVU_OP, 32'd5, 32'd0, lat, res, sok, sdone);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL divu_zero_result: got %h want ffffffff", res); end
        n_checks++; if (lat !== LAT_SPEC) begin n_fails++; $display("FAIL divu_zero_latency: got %0d want %0d", lat, LAT_SPEC); end
        start_op(REM_OP, 32'd5, 32'd0, lat, res, sok, sdone);
        n_checks++; if (res !== 32'd5) begin n_fails++; $display("FAIL rem_zero_result: got %h want 00000005", res); end
        n_checks++; if (lat !== LAT_SPEC) begin n_fails++; $display("FAIL rem_zero_latency: got %0d want %0d", lat, LAT_SPEC); end
        start_op(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sok, sdone);
        n_checks++; if (res !== 32'h8000_0000) begin n_fails++; $display("FAIL div_ovf_result: got %h want 80000000", res); end
        n_checks++; if (lat !== LAT_SPEC) begin n_fails++; $display("FAIL div_ovf_latency: got %0d want %0d", lat, LAT_SPEC); end
        start_op(REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sok, sdone);
        n_checks++; if (res !== 32'h0) begin n_fails++; $display("FAIL rem_ovf_result: got %h want 00000000", res); end
    endtask

    task automatic test_flush_run();
        int lat; logic [XLEN-1:0] res; logic sok, sdone; logic seen_rv;
        start_op(REMU_OP, 32'd100, 32'd7, lat, res, sok, sdone);
        n_checks++; if (res !== 32'd2) begin n_fails++; $display("FAIL flush_pre_result: got %h want 00000002", res); end
        @(posedge clk); #1;
        op = DIVU_OP; opa = 32'd1000; opb = 32'd3; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL flush_run_busy: got %b want 1", busy); end
        flush = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL flush_run_idle: busy %b want 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL flush_run_stall: got %b want 0", stall); end
        start_valid = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL flush_idle_stall: got %b want 1", stall); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL flush_idle_reject: busy %b want 0", busy); end
        flush = 1'b0; start_valid = 1'b0;
        seen_rv = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid === 1'b1) seen_rv = 1'b1;
        end
        n_checks++; if (seen_rv !== 1'b0) begin n_fails++; $display("FAIL flush_no_rv: got %b want 0", seen_rv); end
        n_checks++; if (result !== 32'd2) begin n_fails++; $display("FAIL flush_result_kept: got %h want 00000002", result); end
    endtask

    task automatic test_flush_done();
        int lat; logic [XLEN-1:0] res; logic sok, sdone;
        start_op(DIVU_OP, 32'd100, 32'd7, lat, res, sok, sdone);
        flush = 1'b1;
        #1;
        n_checks++; if (result_valid !== 1'b1) begin n_fails++; $display("FAIL flush_done_rv: got %b want 1", result_valid); end
        n_checks++; if (result !== 32'd14) begin n_fails++; $display("FAIL flush_done_result: got %h want 0000000e", result); end
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL flush_done_idle: rv %b busy %b want 0 0", result_valid, busy); end
        n_checks++; if (result !== 32'd14) begin n_fails++; $display("FAIL flush_done_hold: got %h want 0000000e", result); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [XLEN-1:0] res; logic sok, sdone;
        @(posedge clk); #1;
        op = MUL_OP; opa = 32'd1234; opb = 32'd5678; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_checks++; if (result_valid !== 1'b0) begin n_fails++; $display("FAIL rst_mid_rv: got %b want 0", result_valid); end
        n_checks++; if (result !== '0) begin n_fails++; $display("FAIL rst_mid_result: got %h want 0", result); end
        n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
        start_valid = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL rst_mid_stall_follow: got %b want 1", stall); end
        start_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        start_op(MUL_OP, 32'd3, 32'd4, lat, res, sok, sdone);
        n_checks++; if (res !== 32'd12) begin n_fails++; $display("FAIL post_rst_mul: got %h want 0000000c", res); end
        n_checks++; if (lat !== LAT_NORM) begin n_fails++; $display("FAIL post_rst_latency: got %0d want %0d", lat, LAT_NORM); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush_run();
        test_flush_done();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
